// File: rtl/seg7_digit_monitor.sv
// Decodes synchronised 7-segment lines back to BCD, filters glitches, flags illegal codes and broken 0..9 sequences.
// Latency: accept pulse STABLE_CYCLES+2 edges after the first sampling edge; no backpressure (free-running monitor).
module seg7_digit_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             err_clr,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             invalid_pat,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [6:0] BLANK     = 7'h7F;
  localparam logic [6:0] RAW_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam int         CW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {UNLOCK, LOCK} state_t;

  state_t           state, state_nxt;
  logic [6:0]       sync1, sync2;
  logic [6:0]       pat;
  logic [6:0]       cand, last_acc;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept;
  logic             pat_legal;
  logic [3:0]       pat_digit;
  logic [3:0]       digit_succ;
  logic [3:0]       digit_nxt;
  logic             dv_nxt, inv_nxt, seq_nxt, err_inc;

  // Decode an active-low {a..g} pattern: bit4 = legal digit, bits3:0 = value.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      7'b0000001: r = {1'b1, 4'd0};
      7'b1001111: r = {1'b1, 4'd1};
      7'b0010010: r = {1'b1, 4'd2};
      7'b0000110: r = {1'b1, 4'd3};
      7'b1001100: r = {1'b1, 4'd4};
      7'b0100100: r = {1'b1, 4'd5};
      7'b0100000: r = {1'b1, 4'd6};
      7'b0001111: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0000100: r = {1'b1, 4'd9};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RAW_BLANK;
      sync2 <= RAW_BLANK;
    end else begin
      sync1 <= seg_in;
      sync2 <= sync1;
    end
  end

  assign pat = ACTIVE_LOW ? sync2 : ~sync2;

  // Count of consecutive filter edges on which pat has matched the candidate.
  always_comb begin
    cnt_nxt = cnt;
    if (pat != cand) begin
      cnt_nxt = CW'(1);
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // Accepting updates last_acc, so a held pattern fires only once.
  assign accept = (cnt_nxt == CNT_MAX) && (pat != last_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      cand     <= BLANK;
      cnt      <= '0;
      last_acc <= BLANK;
    end else begin
      cand <= pat;
      cnt  <= cnt_nxt;
      if (accept) begin
        last_acc <= pat;
      end
    end
  end

  assign {pat_legal, pat_digit} = decode(pat);
  assign digit_succ = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    dv_nxt    = 1'b0;
    inv_nxt   = 1'b0;
    seq_nxt   = 1'b0;
    err_inc   = 1'b0;
    if (accept) begin
      if (pat == BLANK) begin
        state_nxt = UNLOCK;
      end else if (!pat_legal) begin
        inv_nxt   = 1'b1;
        err_inc   = 1'b1;
        state_nxt = UNLOCK;
      end else begin
        dv_nxt    = 1'b1;
        digit_nxt = pat_digit;
        state_nxt = LOCK;
        if (state == LOCK && pat_digit != digit_succ) begin
          seq_nxt = 1'b1;
          err_inc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCK;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      invalid_pat <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      digit       <= digit_nxt;
      digit_valid <= dv_nxt;
      invalid_pat <= inv_nxt;
      seq_err     <= seq_nxt;
    end
  end

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (err_inc && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign locked = (state == LOCK);

endmodule
